// File: rtl/oled_tx_pkg.sv
// oled_tx_pkg: shared constants and state encoding for the OLED frame transmitter
package oled_tx_pkg;
    localparam int FRAME_BYTES = 1024;
    localparam int ADDR_W = $clog2(FRAME_BYTES);
    localparam logic [7:0] MUSIC_IDLE = 8'h00;
    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
endpackage

// File: rtl/oled_pingpong_ram.sv
// oled_pingpong_ram: two-bank frame store, one write port, one registered read port
// wr_en/wr_bank/wr_addr/wr_data: write port; rd_bank/rd_addr -> rd_data one cycle later
module oled_pingpong_ram
    import oled_tx_pkg::*;
(
    input  logic              oled_clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    logic [7:0] mem [0:2*FRAME_BYTES-1];
    always_ff @(posedge oled_clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
        rd_data <= mem[{rd_bank, rd_addr}];
    end
endmodule

// File: rtl/oled_frame_tx.sv
// oled_frame_tx: double-buffered frame store streamed out as preamble, data burst and gap
// oled_clk/reset_n: clock and async active-high reset
// wr_en/wr_addr/wr_data/wr_ready: producer writes into the back bank
// frame_commit/frame_drop: back bank complete / commit lost while one is pending
// music_in: latched at each frame start and sent on every dc=0 cycle
// oled_dc/oled_data: output byte stream; busy/frame_done/front_bank: status
module oled_frame_tx
    import oled_tx_pkg::*;
#(
    parameter int PRE_CYCLES = 4,
    parameter int GAP_CYCLES = 16,
    parameter int REPEAT     = 1
) (
    input  logic              oled_clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              frame_commit,
    input  logic [7:0]        music_in,
    output logic              oled_dc,
    output logic [7:0]        oled_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_drop,
    output logic              front_bank
);
    localparam int CW = 16;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic              pending;
    logic [7:0]        music_q;
    logic [7:0]        ram_q;
    logic [ADDR_W-1:0] rd_addr;
    assign wr_ready = ~pending;
    // address 0 is presented outside DATA so it is already fetched in the last PRE cycle
    assign rd_addr = (state == DATA) ? cnt[ADDR_W-1:0] + ADDR_W'(1) : '0;
    // the RAM output register is the data-phase stream register
    assign oled_data = oled_dc ? ram_q : music_q;
    oled_pingpong_ram u_ram (
        .oled_clk(oled_clk),
        .wr_en(wr_en && !pending),
        .wr_bank(~front_bank),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_bank(front_bank),
        .rd_addr(rd_addr),
        .rd_data(ram_q)
    );
    always_ff @(posedge oled_clk or posedge reset_n) begin
        if (reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            front_bank <= 1'b0;
            music_q    <= MUSIC_IDLE;
            oled_dc    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= frame_commit && pending;
            frame_done <= state == DATA && cnt == CW'(FRAME_BYTES - 2);
            pending    <= (state == IDLE && pending) ? 1'b0 : pending || frame_commit;
            case (state)
                IDLE: if (pending || REPEAT != 0) begin
                    front_bank <= front_bank ^ pending;
                    music_q    <= music_in;
                    state      <= PRE;
                    busy       <= 1'b1;
                    cnt        <= '0;
                end
                PRE: if (cnt == CW'(PRE_CYCLES - 1)) begin
                    state   <= DATA;
                    oled_dc <= 1'b1;
                    cnt     <= '0;
                end else cnt <= cnt + CW'(1);
                DATA: if (cnt == CW'(FRAME_BYTES - 1)) begin
                    state   <= GAP;
                    oled_dc <= 1'b0;
                    cnt     <= '0;
                end else cnt <= cnt + CW'(1);
                GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_frame_tx.sv
// tb_oled_frame_tx: scoreboard bench, lane 0 with REPEAT=0 and lane 1 with REPEAT=1
module tb_oled_frame_tx;
    import oled_tx_pkg::*;
    localparam int NPRE = 4, NGAP = 16, FB = FRAME_BYTES, PER = NPRE + FB + NGAP + 1;
    logic oled_clk = 1'b0;
    always #5 oled_clk = ~oled_clk;
    logic [1:0] rst = 2'b11, we = 2'b00, cm = 2'b00;
    logic [1:0] wrdy, dc, busy, done, drop, fb;
    logic [ADDR_W-1:0] wa [2];
    logic [7:0] wd [2], mu [2], dat [2];
    for (genvar g = 0; g < 2; g++) begin : lane
        oled_frame_tx #(.PRE_CYCLES(NPRE), .GAP_CYCLES(NGAP), .REPEAT(g)) dut (
            .oled_clk(oled_clk), .reset_n(rst[g]), .wr_en(we[g]), .wr_addr(wa[g]),
            .wr_data(wd[g]), .wr_ready(wrdy[g]), .frame_commit(cm[g]), .music_in(mu[g]),
            .oled_dc(dc[g]), .oled_data(dat[g]), .busy(busy[g]), .frame_done(done[g]),
            .frame_drop(drop[g]), .front_bank(fb[g])
        );
    end
    logic [7:0] mem [2][2][FB];
    logic [7:0] fs [16][FB];
    logic [7:0] fm [16];
    logic       fbk [16];
    int nf = 0;
    int q0 [$], q1 [$];
    logic [1:0] pend = 2'b00, fbm = 2'b00;
    int exp_drop [2] = '{0, 0}, drops [2] = '{0, 0}, starts [2] = '{0, 0}, known [2] = '{0, 0};
    int idx [2] = '{0, 0}, ph [2] = '{0, 0}, pre_n [2] = '{0, 0}, gap_n [2] = '{0, 0};
    int cur [2] = '{-1, -1}, errs [2] = '{0, 0}, last_start [2] = '{0, 0}, commit_cyc [2] = '{0, 0};
    logic [7:0] pmus [2];
    bit pbad [2] = '{0, 0};
    int cyc = 0, total = 0, bad = 0;

    task automatic check(input string nm, input int l, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s lane%0d: got %0d want %0d", nm, l, act, exp);
        end
    endtask

    task automatic step(input int l, input bit w, input int a, input logic [7:0] d, input bit c);
        we[l] = w;
        wa[l] = a[ADDR_W-1:0];
        wd[l] = d;
        cm[l] = c;
        if (w && !pend[l]) mem[l][~fbm[l]][a] = d;
        if (c) begin
            if (pend[l]) exp_drop[l]++;
            else begin
                pend[l] = 1'b1;
                for (int i = 0; i < FB; i++) fs[nf][i] = mem[l][~fbm[l]][i];
                fm[nf] = mu[l];
                fbk[nf] = ~fbm[l];
                if (l == 0) q0.push_back(nf); else q1.push_back(nf);
                nf++;
                commit_cyc[l] = cyc;
            end
        end
        @(negedge oled_clk);
        we[l] = 1'b0;
        cm[l] = 1'b0;
    endtask

    function automatic int val(input int l, input int w);
        return w == 0 ? starts[l] : w == 1 ? known[l] : idx[l];
    endfunction

    task automatic wait_for(input int l, input int w, input int n);
        int t = 0;
        while (val(l, w) < n && t < 20000) begin
            @(negedge oled_clk);
            t++;
        end
        check("wait_timeout", l, int'(val(l, w) >= n), 1);
    endtask

    task automatic idle_check(input string nm, input int n);
        int badc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge oled_clk);
            if (dc[0] || busy[0] || done[0] || dat[0] != 8'h00) badc++;
        end
        check(nm, 0, badc, 0);
    endtask

    always @(posedge oled_clk) cyc <= cyc + 1;

    always @(negedge oled_clk) begin
        for (int l = 0; l < 2; l++) begin
            if (rst[l]) begin
                ph[l] = 0;
                pre_n[l] = 0;
                cur[l] = -1;
                pbad[l] = 0;
            end else begin
                if (drop[l]) drops[l]++;
                if (dc[l]) begin
                    if (ph[l] != 1) begin
                        int nc;
                        nc = -1;
                        check("pre_len", l, pre_n[l], NPRE);
                        if (l == 0 && q0.size() > 0) nc = q0.pop_front();
                        else if (l == 1 && q1.size() > 0) nc = q1.pop_front();
                        if (nc >= 0) begin
                            cur[l] = nc;
                            pend[l] = 1'b0;
                            fbm[l] = fbk[nc];
                        end else if (l == 0) check("unexpected_burst", l, 1, 0);
                        else if (cur[l] >= 0) check("repeat_period", l, cyc - last_start[l], PER);
                        if (cur[l] >= 0) begin
                            check("pre_music", l, pbad[l] ? -1 : int'(pmus[l]), int'(fm[cur[l]]));
                            check("front_bank", l, int'(fb[l]), int'(fbk[cur[l]]));
                            known[l]++;
                        end
                        starts[l]++;
                        last_start[l] = cyc;
                        ph[l] = 1;
                        idx[l] = 0;
                        errs[l] = 0;
                    end
                    if (cur[l] >= 0 && idx[l] < FB && dat[l] !== fs[cur[l]][idx[l]]) errs[l]++;
                    if (done[l] !== (idx[l] == FB - 1)) errs[l]++;
                    if (!busy[l]) errs[l]++;
                    idx[l]++;
                end else begin
                    if (ph[l] == 1) begin
                        check("burst_len", l, idx[l], FB);
                        check("burst_data", l, errs[l], 0);
                        ph[l] = 2;
                        gap_n[l] = 0;
                        pbad[l] = 0;
                    end
                    if (done[l]) pbad[l] = 1;
                    if (busy[l]) begin
                        if (ph[l] == 0) begin
                            if (pre_n[l] == 0) pmus[l] = dat[l];
                            else if (dat[l] !== pmus[l]) pbad[l] = 1;
                            pre_n[l]++;
                        end else begin
                            gap_n[l]++;
                            if (cur[l] >= 0 && dat[l] !== fm[cur[l]]) pbad[l] = 1;
                        end
                    end else begin
                        if (ph[l] == 2) begin
                            check("gap_len", l, gap_n[l], NGAP);
                            check("gap_music", l, int'(pbad[l]), 0);
                        end
                        ph[l] = 0;
                        pre_n[l] = 0;
                        pbad[l] = 0;
                    end
                end
            end
        end
    end

    initial begin
        wa[0] = '0; wa[1] = '0;
        wd[0] = 8'h00; wd[1] = 8'h00;
        mu[0] = 8'h00; mu[1] = 8'h3C;
        repeat (3) @(negedge oled_clk);
        check("rst_dc", 0, int'(dc[0]), 0);
        check("rst_data", 0, int'(dat[0]), 0);
        check("rst_busy", 0, int'(busy[0]), 0);
        check("rst_done", 0, int'(done[0]), 0);
        check("rst_drop", 0, int'(drop[0]), 0);
        check("rst_front", 0, int'(fb[0]), 0);
        check("rst_ready", 0, int'(wrdy[0]), 1);
        #1 rst[0] = 1'b0;
        idle_check("idle_no_commit", 2000);
        mu[0] = 8'hA5;
        for (int i = 0; i < FB; i++) step(0, 1'b1, i, i[7:0], i == FB - 1);
        check("ready_after_commit", 0, int'(wrdy[0]), 0);
        wait_for(0, 0, 1);
        check("commit_latency", 0, last_start[0] - commit_cyc[0], NPRE + 2);
        for (int i = 0; i < FB; i++) step(0, 1'b1, i, 8'($urandom), 1'b0);
        mu[0] = 8'($urandom);
        step(0, 1'b0, 0, 8'h00, 1'b1);
        wait_for(0, 0, 2);
        for (int i = 0; i < 20; i++) step(0, 1'b1, int'($urandom_range(FB - 1, 16)), 8'($urandom), 1'b0);
        mu[0] = 8'($urandom);
        step(0, 1'b0, 0, 8'h00, 1'b1);
        check("ready_pending", 0, int'(wrdy[0]), 0);
        step(0, 1'b1, 5, 8'hFF, 1'b0);
        step(0, 1'b0, 0, 8'h00, 1'b1);
        check("drop_pulse", 0, int'(drop[0]), 1);
        @(negedge oled_clk);
        check("drop_single", 0, int'(drop[0]), 0);
        check("ready_still_low", 0, int'(wrdy[0]), 0);
        wait_for(0, 0, 3);
        mu[0] = 8'($urandom);
        step(0, 1'b0, 0, 8'h00, 1'b1);
        wait_for(0, 0, 4);
        wait_for(0, 2, 300);
        #1 rst[0] = 1'b1;
        #1;
        check("abort_dc", 0, int'(dc[0]), 0);
        check("abort_data", 0, int'(dat[0]), 0);
        check("abort_busy", 0, int'(busy[0]), 0);
        check("abort_front", 0, int'(fb[0]), 0);
        check("abort_ready", 0, int'(wrdy[0]), 1);
        pend[0] = 1'b0;
        fbm[0] = 1'b0;
        q0.delete();
        repeat (2) @(negedge oled_clk);
        #1 rst[0] = 1'b0;
        idle_check("idle_after_reset", 200);
        mu[0] = 8'($urandom);
        step(0, 1'b0, 0, 8'h00, 1'b1);
        wait_for(0, 0, 5);
        check("commit_latency2", 0, last_start[0] - commit_cyc[0], NPRE + 2);
        begin
            int t = 0;
            while ((busy[0] || q0.size() > 0) && t < 20000) begin
                @(negedge oled_clk);
                t++;
            end
            check("lane0_idle_timeout", 0, int'(busy[0]), 0);
        end
        #1 rst[1] = 1'b0;
        for (int i = 0; i < FB; i++) step(1, 1'b1, i, 8'($urandom), i == FB - 1);
        wait_for(1, 1, 4);
        check("repeat_front", 1, int'(fb[1]), 1);
        check("drop_count", 0, drops[0], exp_drop[0]);
        check("drop_count", 1, drops[1], exp_drop[1]);
        check("queue_left", 0, q0.size(), 0);
        check("queue_left", 1, q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/oled_frame_tx.md
Name: oled_frame_tx

Overview:
- Transmit end of the OLED byte-stream link. Emits the oled_dc/oled_data stream that the display-side framebuffer receiver consumes on the same oled_clk.
- Holds a double-buffered 1024-byte page-format frame store (8 pages x 128 columns, LSB = top pixel). A producer fills the back bank while the front bank streams out as one contiguous dc=1 burst.
- Every dc=0 cycle carries the latched music byte, which the receiver samples as its music data.

Parameters:
- FRAME_BYTES, 1024: data bytes per frame. Fixed power of two; the address counter wraps naturally.
- ADDR_W, 10: log2(FRAME_BYTES).
- PRE_CYCLES, 4: dc=0 preamble cycles before each data burst. Minimum 1; the receiver needs at least one dc=0 cycle to reset its write address.
- GAP_CYCLES, 16: dc=0 cycles after each data burst before the block returns to IDLE.
- REPEAT, 1: 1 = retransmit the front bank when no new frame is pending; 0 = stay idle.

Ports:
- oled_clk  in  1  sole clock, all logic on posedge
- reset_n  in  1  asynchronous, active-high reset
- wr_en  in  1  producer write strobe
- wr_addr  in  ADDR_W  byte address in back bank
- wr_data  in  8  byte to write
- wr_ready  out  1  writes accepted; equals ~pending
- frame_commit  in  1  single-cycle pulse: back bank complete
- music_in  in  8  sampled once per frame at preamble start
- oled_dc  out  1  registered; 1 = frame data byte, 0 = preamble/gap/idle
- oled_data  out  8  registered stream byte
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on the cycle the last data byte is driven
- frame_drop  out  1  one-cycle pulse: commit arrived while already pending
- front_bank  out  1  bank currently being / last transmitted

Behaviour:
- Reset (async, reset_n=1) sets:
  - state=IDLE, oled_dc=0, oled_data=0x00;
  - pending=0, front_bank=0;
  - all counters 0; busy, frame_done, frame_drop all 0.
  - RAM contents are not cleared. A mid-frame reset aborts immediately: oled_dc falls with reset, not at the next edge.
- Writes:
  - Accepted only when wr_en && wr_ready, into bank ~front_bank, at wr_addr.
  - Writes while pending=1 are ignored, so the bank being swapped is never corrupted.
- Commit:
  - frame_commit with pending=0 sets pending on that edge.
  - frame_commit with pending=1 pulses frame_drop next cycle; pending stays 1.
- States IDLE -> PRE -> DATA -> GAP -> IDLE.
- IDLE: oled_dc=0; oled_data holds the latched music byte.
  - If pending: toggle front_bank, clear pending, latch music_in, go to PRE.
  - Else if REPEAT: latch music_in and go to PRE without a swap.
- PRE: PRE_CYCLES cycles, oled_dc=0, oled_data=music byte. The RAM read of address 0 is issued in the last PRE cycle (1-cycle read latency).
- DATA: exactly FRAME_BYTES consecutive cycles, oled_dc=1, oled_data = front[i] for i=0..FRAME_BYTES-1.
  - No stalls and no bubbles.
  - frame_done pulses on the cycle front[FRAME_BYTES-1] is driven.
- GAP: GAP_CYCLES cycles, oled_dc=0, oled_data=music byte, then IDLE.
- Latency: commit sampled at edge c; IDLE swaps at edge c+1; first PRE byte visible after edge c+1. The first data byte appears PRE_CYCLES cycles later.
- A commit during PRE/DATA/GAP only sets pending; the frame in flight is never affected, and the swap happens at the next IDLE.
- Simultaneous wr_en and frame_commit at the same edge with pending=0: the write lands, and the commit takes effect.

Decomposition:
- Package oled_tx_pkg: state enum (IDLE, PRE, DATA, GAP), FRAME_BYTES/ADDR_W constants, MUSIC_IDLE default 0x00.
- Sub-module oled_pingpong_ram: 2 x FRAME_BYTES x 8, one write port (bank, addr, data, en), one registered read port (bank, addr). Inferable as block RAM.

Test Plan:
- Reset release, REPEAT=0, no commit -> oled_dc stays 0, oled_data=0x00, busy=0 for 2000 cycles.
- Write bank1 with byte[i]=i[7:0], commit, music_in=0xA5 -> PRE_CYCLES cycles dc=0/data=0xA5. Then 1024 cycles dc=1 with data 0x00..0xFF repeating four times, frame_done on byte 1023, then 16 gap cycles, front_bank=1.
- Commit during DATA, then a second commit -> frame_drop pulses once, wr_ready=0. Current frame completes unchanged; the next frame starts from the other bank after GAP.
- Write attempts while wr_ready=0 (addr 5, 0xFF) -> the transmitted next frame's byte 5 keeps its pre-commit value.
- REPEAT=1, one commit, no further commits -> the identical 1024-byte burst is retransmitted every PRE+1024+GAP+1 cycles, front_bank constant.
- reset_n asserted at data byte 300 -> oled_dc=0 and oled_data=0x00 immediately. After release, the block idles until a commit (REPEAT=0).
